// File: rtl/uart_pkg.sv
// Shared UART receive definitions: parity modes, frame-checker states and
// legal parameter ranges.
package uart_pkg;

  localparam logic [1:0] PAR_ODD   = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_SPACE = 2'b10;
  localparam logic [1:0] PAR_MARK  = 2'b11;

  localparam int unsigned DATA_WIDTH_MIN = 5;
  localparam int unsigned DATA_WIDTH_MAX = 9;
  localparam int unsigned STOP_BITS_MIN  = 1;
  localparam int unsigned STOP_BITS_MAX  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StParity,
    StStop,
    StDone
  } rx_state_e;

  // data_xor is the XOR of all data bits received in the frame
  function automatic logic expected_parity(input logic [1:0] mode, input logic data_xor);
    logic exp_bit;
    unique case (mode)
      PAR_ODD:   exp_bit = ~data_xor;
      PAR_EVEN:  exp_bit = data_xor;
      PAR_SPACE: exp_bit = 1'b0;
      PAR_MARK:  exp_bit = 1'b1;
      default:   exp_bit = 1'b0;
    endcase
    return exp_bit;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_frame_check.sv
// Bit-serial UART frame checker: LSB-first data accumulation, optional parity
// check, one or two stop bits, per-frame error flags and saturating error counters.
module uart_rx_frame_check
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk2,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_data,
  input  logic                  parity_en,
  input  logic [1:0]            parity_type,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  frame_done,
  output logic                  par_err,
  output logic                  stop_err,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stop_err_cnt
);

  localparam int unsigned BitCntW = 4;

  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_data_width
    $error("DATA_WIDTH out of legal range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("STOP_BITS out of legal range");
  end

  rx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic                  par_err_int_q, par_err_int_d;
  logic                  stop_err_int_q, stop_err_int_d;
  logic                  pen_q, pen_d;
  logic [1:0]            ptype_q, ptype_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    par_d          = par_q;
    bit_cnt_d      = bit_cnt_q;
    par_err_int_d  = par_err_int_q;
    stop_err_int_d = stop_err_int_q;
    pen_d          = pen_q;
    ptype_d        = ptype_q;
    p_data_d       = p_data_q;
    par_err_d      = par_err_q;
    stop_err_d     = stop_err_q;

    // A start pulse in any state (re)starts a frame and drops a same-cycle bit.
    if (frame_start) begin
      state_d        = StData;
      shift_d        = '0;
      par_d          = 1'b0;
      bit_cnt_d      = '0;
      par_err_int_d  = 1'b0;
      stop_err_int_d = 1'b0;
      pen_d          = parity_en;
      ptype_d        = parity_type;
    end else begin
      unique case (state_q)
        StIdle: begin
          shift_d        = '0;
          par_d          = 1'b0;
          bit_cnt_d      = '0;
          par_err_int_d  = 1'b0;
          stop_err_int_d = 1'b0;
        end
        StData: begin
          if (bit_valid) begin
            shift_d = {sampled_data, shift_q[DATA_WIDTH-1:1]};
            par_d   = par_q ^ sampled_data;
            if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
              bit_cnt_d = '0;
              state_d   = pen_q ? StParity : StStop;
            end else begin
              bit_cnt_d = bit_cnt_q + BitCntW'(1);
            end
          end
        end
        StParity: begin
          if (bit_valid) begin
            par_err_int_d = (sampled_data != expected_parity(ptype_q, par_q));
            state_d       = StStop;
          end
        end
        StStop: begin
          if (bit_valid) begin
            stop_err_int_d = stop_err_int_q | ~sampled_data;
            if (bit_cnt_q == BitCntW'(STOP_BITS - 1)) begin
              bit_cnt_d = '0;
              state_d   = StDone;
              // Publish on entry so results are valid alongside frame_done.
              p_data_d   = shift_q;
              par_err_d  = par_err_int_q;
              stop_err_d = stop_err_int_q | ~sampled_data;
            end else begin
              bit_cnt_d = bit_cnt_q + BitCntW'(1);
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      shift_q        <= '0;
      par_q          <= 1'b0;
      bit_cnt_q      <= '0;
      par_err_int_q  <= 1'b0;
      stop_err_int_q <= 1'b0;
      pen_q          <= 1'b0;
      ptype_q        <= PAR_ODD;
      p_data_q       <= '0;
      par_err_q      <= 1'b0;
      stop_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      par_q          <= par_d;
      bit_cnt_q      <= bit_cnt_d;
      par_err_int_q  <= par_err_int_d;
      stop_err_int_q <= stop_err_int_d;
      pen_q          <= pen_d;
      ptype_q        <= ptype_d;
      p_data_q       <= p_data_d;
      par_err_q      <= par_err_d;
      stop_err_q     <= stop_err_d;
    end
  end

  assign frame_done = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign p_data     = p_data_q;
  assign par_err    = par_err_q;
  assign stop_err   = stop_err_q;

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_par_cnt (
    .clk_i  (clk2),
    .rst_ni (rst),
    .inc_i  (frame_done && par_err_q),
    .clr_i  (err_clr),
    .count_o(par_err_cnt)
  );

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stop_cnt (
    .clk_i  (clk2),
    .rst_ni (rst),
    .inc_i  (frame_done && stop_err_q),
    .clr_i  (err_clr),
    .count_o(stop_err_cnt)
  );

endmodule

// File: doc/uart_rx_frame_check.md
Name: uart_rx_frame_check

Overview:
Bit-serial frame checker for the UART receiver. It consumes sampled bits one `bit_valid` strobe at a time and accumulates data LSB-first with a running parity. It then checks the optional parity bit and one or two stop bits, and publishes the data word with per-frame error flags and saturating error counters. It sits between the RX oversampler/sampler and the RX FSM/host interface, replacing the single-shot byte parity checker.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits checked; 1 or 2.
- CNT_WIDTH, 8, width of each saturating error counter.

Ports:
- clk2  input  1  receiver clock.
- rst  input  1  reset; asynchronous, active-low.
- frame_start  input  1  start bit detected; begins a new frame (1-cycle pulse).
- bit_valid  input  1  `sampled_data` holds a new frame bit this cycle.
- sampled_data  input  1  sampled serial bit.
- parity_en  input  1  frame carries a parity bit; latched at `frame_start`.
- parity_type  input  2  00 odd, 01 even, 10 space (always 0), 11 mark (always 1); latched at `frame_start`.
- err_clr  input  1  synchronous clear of both error counters.
- p_data  output  DATA_WIDTH  last completed data word.
- frame_done  output  1  1-cycle pulse when a frame completes.
- par_err  output  1  parity error of last completed frame.
- stop_err  output  1  any stop bit sampled 0 in last completed frame.
- busy  output  1  state != IDLE.
- par_err_cnt  output  CNT_WIDTH  saturating count of parity errors.
- stop_err_cnt  output  CNT_WIDTH  saturating count of stop errors.

Behaviour:
- Reset values: `p_data`=0, `frame_done`=0, `par_err`=0, `stop_err`=0, `busy`=0, both counters=0, state=IDLE, internal shift/parity/bit counter=0.
- States: IDLE, DATA, PARITY, STOP, DONE.
- IDLE:
  - `frame_start` -> DATA.
  - Clear the shift register, running parity, bit counter, par_err_int and stop_err_int.
  - Latch `parity_en` and `parity_type`.
- DATA:
  - Each `bit_valid` shifts `sampled_data` in LSB-first (first bit lands in bit 0 once the word is full) and XORs it into the running parity.
  - After DATA_WIDTH bits: -> PARITY if the latched `parity_en`=1, else -> STOP.
- PARITY: on `bit_valid`, compute the expected bit and set par_err_int = (sampled_data != expected), then -> STOP. Expected bit by mode:
  - even: ^data
  - odd: ~^data
  - space: 0
  - mark: 1
- STOP:
  - Each `bit_valid`: stop_err_int |= ~sampled_data.
  - After STOP_BITS bits -> DONE.
- DONE (exactly one cycle), then -> IDLE:
  - `frame_done`=1.
  - `p_data` <= shift register; `par_err` <= par_err_int; `stop_err` <= stop_err_int.
  - Increment each counter whose error is set.
- Output timing:
  - `frame_done` rises the cycle after the clock edge that consumes the last stop bit.
  - `p_data`, `par_err` and `stop_err` are valid in that cycle and hold until the next DONE.
- Parity disabled: `par_err` is always 0 for that frame.
- `bit_valid` outside DATA/PARITY/STOP is ignored. Cycles without `bit_valid` hold all state.
- `frame_start` in any non-IDLE state aborts the current frame:
  - Restart DATA with cleared accumulators and newly latched config.
  - No `frame_done`; outputs and counters unchanged.
- `frame_start` together with `bit_valid` in the same cycle: the start wins and the bit is discarded.
- Counters saturate at all-ones with no wrap.
- `err_clr` sets both counters to 0. If asserted in the DONE cycle, clear wins over increment.
- Config changes mid-frame have no effect until the next `frame_start`.
- Asynchronous reset mid-frame returns to reset values immediately; no `frame_done` is produced.

Decomposition:
- Shared package (uart_pkg) holds:
  - parity mode encodings PAR_ODD=2'b00, PAR_EVEN=2'b01, PAR_SPACE=2'b10, PAR_MARK=2'b11;
  - state encodings;
  - the DATA_WIDTH/STOP_BITS legal-range constants.
- One natural sub-module: `sat_counter` (CNT_WIDTH, inc, clr, count), instantiated twice.

Test Plan:
- 8-bit data 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first), even parity, parity bit 0, stop 1 -> `frame_done` pulse, `p_data`=8'hA5, `par_err`=0, `stop_err`=0, counters unchanged.
- Same frame with parity bit 1 -> `par_err`=1, `par_err_cnt` 0->1. Odd mode with parity bit 1 -> `par_err`=0.
- Mark/space modes: space with parity bit 1 -> `par_err`=1; mark with parity bit 1 -> `par_err`=0, independent of data.
- STOP_BITS=2, `parity_en`=0, data 0x3C, stops 1 then 0 -> `stop_err`=1, `par_err`=0, `stop_err_cnt`=1. Also check `bit_valid` gaps of 0..5 cycles produce the same result.
- Abort: `frame_start` after 4 data bits, then a full valid frame 0x5A -> exactly one `frame_done`, `p_data`=8'h5A. Async reset mid-frame -> all outputs 0, `busy`=0.
- CNT_WIDTH=2: 5 bad-parity frames -> `par_err_cnt` saturates at 3. `err_clr` asserted in the DONE cycle of a bad frame -> counter reads 0.
